axil_wr_slv: RTL
================

// Module: axil_wr_slv
// PURPOSE
// - AXI4-Lite write responder: terminating end of the DMA write channel, for DMA-mapped local memory/register banks.
// - Accepts AW and W independently (either order), issues one local memory write, returns a B response.
// - One transaction in flight; all AXI outputs registered.
// PARAMETERS
// - ADDR_WIDTH  16              byte-address width of AW channel
// - DATA_WIDTH  64              W data width; multiple of 8
// - STRB_WIDTH  DATA_WIDTH/8    byte-strobe width (derived; do not override)
// - MEM_BYTES   4096            mapped region size in bytes; used only with AXIL_WR_SLV_ADDR_CHECK_EN
// - Local parameter OFS = $clog2(STRB_WIDTH); MEM_AW = ADDR_WIDTH-OFS
// PORTS
// - aclk         in   1           clock; all logic on rising edge
// - areset       in   1           synchronous reset, active-high
// - aenable      in   1           clock enable; low freezes every register
// - i_awaddr     in   ADDR_WIDTH  write byte address
// - i_awprot     in   3           protection; captured and ignored
// - i_awvalid    in   1           AW valid
// - o_awready    out  1           AW ready
// - i_wdata      in   DATA_WIDTH  write data
// - i_wstrb      in   STRB_WIDTH  byte strobes
// - i_wvalid     in   1           W valid
// - o_wready     out  1           W ready
// - o_bresp      out  2           response: 2'b00 OKAY, 2'b10 SLVERR
// - o_bvalid     out  1           B valid
// - i_bready     in   1           B ready
// - o_mem_wr_en  out  1           one-cycle local write strobe
// - o_mem_addr   out  MEM_AW      word address = awaddr[ADDR_WIDTH-1:OFS]
// - o_mem_data   out  DATA_WIDTH  write data
// - o_mem_strb   out  STRB_WIDTH  byte enables
// BEHAVIOUR
// - Reset (areset=1 on edge): all outputs 0, state IDLE, holding slots empty; overrides aenable.
// - aenable=0: no state change; outputs hold; handshakes visible on ports are not consumed.
// - AW slot: o_awready = IDLE & ~aw_full; AW handshake loads addr, sets aw_full. W slot identical with o_wready.
// - States: IDLE -> WRITE when aw_full&w_full (incl. both loaded in same cycle: transition next edge).
//   WRITE (1 cycle): o_mem_wr_en=1 unless error; o_bresp computed; -> RESP with o_bvalid=1.
//   RESP: hold o_bvalid/o_bresp stable until i_bready; on handshake clear slots, o_bvalid=0, -> IDLE.
// - Latency: AW+W accepted edge N -> o_mem_wr_en high cycle N+1 -> o_bvalid high cycle N+2.
// - o_awready/o_wready low in WRITE/RESP; next AW/W accepted first IDLE cycle after B handshake.
// - i_bready already high when o_bvalid rises: handshake on first RESP cycle; no extra bubble.
// - o_mem_* data/addr/strb registered from slots, valid only while o_mem_wr_en=1; stay at last value otherwise.
// - i_wstrb=0: o_mem_wr_en still pulses with strb 0; bresp OKAY.
// - Reset mid-transaction: pending write dropped, no mem write, no B response.
// CONFIGURATION
// - AXIL_WR_SLV_ADDR_CHECK_EN defined: SLVERR when awaddr >= MEM_BYTES or awaddr[OFS-1:0] != 0;
//   erroring write suppresses o_mem_wr_en; B still returned.
// - Not defined: always OKAY; address upper bits beyond mem range passed through; low OFS bits dropped.
// STRUCTURE
// - Shared package axil_pkg: AXIL_RESP_OKAY=2'b00, AXIL_RESP_SLVERR=2'b10, typedef enum axil_wr_slv_st_e {IDLE,WRITE,RESP}.
// - Sub-module axil_wr_slv_slot: parameterised one-entry holding register (valid/ready, load, clear); instanced for AW and W.
// TESTING
// - AW 0x0010 and W 0xDEADBEEF_CAFEF00D/strb 0xFF same cycle, bready=1 -> mem_wr_en cycle N+1 addr 0x002, bvalid N+2 bresp 00.
// - W first, AW 3 cycles later -> awready stays high, wready low after W; single mem write addr 0x002, one B.
// - bready held low 5 cycles -> bvalid/bresp stable, awready/wready low; release -> IDLE, readies high next cycle.
// - CHECK_EN, MEM_BYTES=4096: AW 0x1000 -> no mem_wr_en, bresp 10; AW 0x0003 -> bresp 10; without macro both OKAY, writes issued.
// - areset asserted in WRITE state -> next cycle all outputs 0, no bvalid; fresh AW/W then completes normally.
// - aenable=0 for 4 cycles mid-RESP with bready=1 -> bvalid held, no handshake consumed; completes after aenable=1.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes and write-responder state encoding
//
// Purpose: constants and types shared by the AXI4-Lite write responder files.
// Ports:   none (package).
package axil_pkg;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RESP  = 2'd2
   } axil_wr_slv_st_e;

endpackage

// File: rtl/axil_wr_slv_if.sv
// rtl/axil_wr_slv_if.sv - AXI4-Lite write-channel bundle (AW, W, B)
//
// Purpose: groups the write address, write data and write response channels.
// Ports (as signals, directions seen from the slave):
//   i_awaddr/i_awprot/i_awvalid -> o_awready   write address channel
//   i_wdata/i_wstrb/i_wvalid    -> o_wready    write data channel
//   o_bresp/o_bvalid            <- i_bready    write response channel
// Modports: master drives the i_* signals, slave drives the o_* signals.
interface axil_wr_slv_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 64
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] i_awaddr;
   logic [2:0]            i_awprot;
   logic                  i_awvalid;
   logic                  o_awready;
   logic [DATA_WIDTH-1:0] i_wdata;
   logic [STRB_WIDTH-1:0] i_wstrb;
   logic                  i_wvalid;
   logic                  o_wready;
   logic [1:0]            o_bresp;
   logic                  o_bvalid;
   logic                  i_bready;

   modport master (
      output i_awaddr, i_awprot, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
      input  o_awready, o_wready, o_bresp, o_bvalid
   );

   modport slave (
      input  i_awaddr, i_awprot, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
      output o_awready, o_wready, o_bresp, o_bvalid
   );

endinterface

// File: rtl/axil_wr_slv_slot.sv
// rtl/axil_wr_slv_slot.sv - one-entry holding register with registered ready
//
// Purpose: captures one beat of a valid/ready channel and holds it until cleared.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           clock enable; low freezes every register
//   in_valid     upstream valid
//   in_ready     upstream ready (registered)
//   in_data      upstream payload
//   accept       the owner will be able to take entries next cycle
//   clear        drop the held entry
//   full         entry held
//   data         held payload
module axil_wr_slv_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             accept,
   input  logic             clear,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   logic fire;
   logic full_nx;

   assign fire    = in_valid & in_ready;
   // clear and fire never coincide: in_ready is low whenever the owner clears.
   assign full_nx = clear ? 1'b0 : (fire | full);

   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 1'b0;
         in_ready <= 1'b0;
         data     <= '0;
      end else if (en) begin
         full <= full_nx;
         // Ready is looked ahead one cycle so it is a plain flop on the port.
         in_ready <= accept & ~full_nx;
         if (fire) begin
            data <= in_data;
         end
      end
   end

endmodule

// File: rtl/axil_wr_slv.sv
// rtl/axil_wr_slv.sv - AXI4-Lite write responder driving a local memory write port
//
// Purpose: accepts AW and W independently, issues one local memory write,
//          returns a B response. One transaction in flight; AXI outputs registered.
// Optional feature: define AXIL_WR_SLV_ADDR_CHECK_EN to answer SLVERR (and
//          suppress the memory write) for out-of-range or misaligned addresses.
// Ports:
//   aclk, areset, aenable   clock, synchronous active-high reset, clock enable
//   s_axil                  AW/W/B channels (slave modport)
//   o_mem_wr_en             one-cycle local write strobe
//   o_mem_addr              word address (awaddr without byte-offset bits)
//   o_mem_data, o_mem_strb  write data and byte enables
module axil_wr_slv
   import axil_pkg::*;
#(
   parameter  int ADDR_WIDTH = 16,
   parameter  int DATA_WIDTH = 64,
   parameter  int MEM_BYTES  = 4096,
   localparam int STRB_WIDTH = DATA_WIDTH / 8,
   localparam int OFS        = $clog2(STRB_WIDTH),
   localparam int MEM_AW     = ADDR_WIDTH - OFS
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  aenable,
   axil_wr_slv_if.slave          s_axil,
   output logic                  o_mem_wr_en,
   output logic [MEM_AW-1:0]     o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic [STRB_WIDTH-1:0] o_mem_strb
);

   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

   axil_wr_slv_st_e st, st_nx;

   logic                             accept;
   logic                             clear;
   logic                             aw_full;
   logic                             w_full;
   logic [ADDR_WIDTH+2:0]            aw_slot;
   logic [DATA_WIDTH+STRB_WIDTH-1:0] w_slot;
   logic [ADDR_WIDTH-1:0]            aw_addr;
   logic [2:0]                       aw_prot;
   logic [DATA_WIDTH-1:0]            w_data;
   logic [STRB_WIDTH-1:0]            w_strb;
   logic                             addr_err;
   logic                             unused_slot;

   logic                  mem_wr_en_nx;
   logic [MEM_AW-1:0]     mem_addr_nx;
   logic [DATA_WIDTH-1:0] mem_data_nx;
   logic [STRB_WIDTH-1:0] mem_strb_nx;
   logic                  bvalid_nx;
   logic [1:0]            bresp_nx;

   axil_wr_slv_slot #(.WIDTH(ADDR_WIDTH + 3)) u_aw_slot (
      .clk      (aclk),
      .rst      (areset),
      .en       (aenable),
      .in_valid (s_axil.i_awvalid),
      .in_ready (s_axil.o_awready),
      .in_data  ({s_axil.i_awprot, s_axil.i_awaddr}),
      .accept   (accept),
      .clear    (clear),
      .full     (aw_full),
      .data     (aw_slot)
   );

   axil_wr_slv_slot #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_slot (
      .clk      (aclk),
      .rst      (areset),
      .en       (aenable),
      .in_valid (s_axil.i_wvalid),
      .in_ready (s_axil.o_wready),
      .in_data  ({s_axil.i_wstrb, s_axil.i_wdata}),
      .accept   (accept),
      .clear    (clear),
      .full     (w_full),
      .data     (w_slot)
   );

   assign aw_addr = aw_slot[ADDR_WIDTH-1:0];
   assign aw_prot = aw_slot[ADDR_WIDTH+2:ADDR_WIDTH];
   assign w_data  = w_slot[DATA_WIDTH-1:0];
   assign w_strb  = w_slot[DATA_WIDTH+STRB_WIDTH-1:DATA_WIDTH];

`ifdef AXIL_WR_SLV_ADDR_CHECK_EN
   assign addr_err    = ({1'b0, aw_addr} >= MEM_LIMIT) || (aw_addr[OFS-1:0] != '0);
   assign unused_slot = &{1'b0, aw_prot};
`else
   // Without checking, byte-offset bits are simply dropped and upper bits pass through.
   assign addr_err    = 1'b0;
   assign unused_slot = &{1'b0, aw_prot, aw_addr[OFS-1:0], MEM_LIMIT};
`endif

   // Slots may load again only once the machine is heading back to IDLE.
   assign accept = (st_nx == IDLE);

   always_ff @(posedge aclk) begin
      if (areset) begin
         st              <= IDLE;
         o_mem_wr_en     <= 1'b0;
         o_mem_addr      <= '0;
         o_mem_data      <= '0;
         o_mem_strb      <= '0;
         s_axil.o_bvalid <= 1'b0;
         s_axil.o_bresp  <= AXIL_RESP_OKAY;
      end else if (aenable) begin
         st              <= st_nx;
         o_mem_wr_en     <= mem_wr_en_nx;
         o_mem_addr      <= mem_addr_nx;
         o_mem_data      <= mem_data_nx;
         o_mem_strb      <= mem_strb_nx;
         s_axil.o_bvalid <= bvalid_nx;
         s_axil.o_bresp  <= bresp_nx;
      end
   end

   always_comb begin
      st_nx        = st;
      clear        = 1'b0;
      mem_wr_en_nx = 1'b0;
      mem_addr_nx  = o_mem_addr;
      mem_data_nx  = o_mem_data;
      mem_strb_nx  = o_mem_strb;
      bvalid_nx    = s_axil.o_bvalid;
      bresp_nx     = s_axil.o_bresp;
      case (st)
         IDLE: begin
            if (aw_full && w_full) begin
               st_nx        = WRITE;
               mem_wr_en_nx = ~addr_err;
               mem_addr_nx  = aw_addr[ADDR_WIDTH-1:OFS];
               mem_data_nx  = w_data;
               mem_strb_nx  = w_strb;
            end
         end
         WRITE: begin
            st_nx     = RESP;
            bvalid_nx = 1'b1;
            bresp_nx  = addr_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
         end
         RESP: begin
            if (s_axil.i_bready) begin
               st_nx     = IDLE;
               bvalid_nx = 1'b0;
               clear     = 1'b1;
            end
         end
         default: begin
            st_nx = IDLE;
         end
      endcase
   end

endmodule
